apb_req_arbiter: RTL

Two-requester round-robin arbiter and sequencer in front of the APB master's command interface.
- Latches one requester's command and drives `transfer`/`read_write`/address/data into the master.
- Watches the APB bus (`penable`, `pready`, `prdata`) to detect completion and returns read data plus a done pulse to the winning requester.
- A watchdog aborts transfers that never complete.

---
 rtl/apb_req_arbiter_if.sv | 39 +++
 rtl/apb_req_arbiter.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/apb_req_arbiter_if.sv
// Requester, APB-master command and bus-monitor signals of the request arbiter.
// The arbiter connects through the master modport; the environment driving the
// requesters and the bus uses the slave modport.
interface apb_req_arbiter_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  // requester side
  logic              req0, req1;
  logic              rw0, rw1;
  logic [ADDR_W-1:0] addr0, addr1;
  logic [DATA_W-1:0] wdata0, wdata1;
  logic              gnt0, gnt1;
  logic              done0, done1;
  logic              err;
  logic [DATA_W-1:0] rdata;
  // command to the APB master
  logic              transfer;
  logic              read_write;
  logic [ADDR_W-1:0] apb_write_paddr, apb_read_paddr;
  logic [DATA_W-1:0] apb_write_data;
  // bus monitor
  logic              penable, pready;
  logic [DATA_W-1:0] prdata;

  modport master (
    input  req0, req1, rw0, rw1, addr0, addr1, wdata0, wdata1,
    input  penable, pready, prdata,
    output gnt0, gnt1, done0, done1, err, rdata,
    output transfer, read_write, apb_write_paddr, apb_read_paddr, apb_write_data
  );

  modport slave (
    output req0, req1, rw0, rw1, addr0, addr1, wdata0, wdata1,
    output penable, pready, prdata,
    input  gnt0, gnt1, done0, done1, err, rdata,
    input  transfer, read_write, apb_write_paddr, apb_read_paddr, apb_write_data
  );
endinterface

// File: rtl/apb_req_arbiter.sv
// Two-requester round-robin arbiter in front of an APB master command port.
// IDLE arbitrates and latches the winner's command, XFER holds transfer until
// the bus completes (penable & pready) or the watchdog expires, DONE pulses the
// winner's done (with err on timeout) for one cycle.

// Per-requester grant/done flops.
module apb_req_arbiter_lane (
  input  logic pclk,
  input  logic preset,
  input  logic grant,   // won arbitration this cycle
  input  logic finish,  // transaction ends this cycle
  input  logic retire,  // DONE cycle, everything clears
  output logic gnt,
  output logic done
);
  // grant spans XFER+DONE, done spans DONE only
  always_ff @(posedge pclk or negedge preset) begin
    if (!preset) begin
      gnt  <= 1'b0;
      done <= 1'b0;
    end else begin
      if (grant)       gnt <= 1'b1;
      else if (retire) gnt <= 1'b0;
      if (finish)      done <= 1'b1;
      else if (retire) done <= 1'b0;
    end
  end
endmodule

module apb_req_arbiter #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 16
) (
  input  logic                pclk,
  input  logic                preset,
  apb_req_arbiter_if.master   bus
);
  localparam int NUM_REQ = 2;
  localparam int CNT_W   = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef struct packed {
    logic              rw;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } cmd_t;

  typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;

  state_t                   state, state_nxt;
  logic   [NUM_REQ-1:0]     req, gnt, done, grant, finish;
  cmd_t   [NUM_REQ-1:0]     cmd_in;
  cmd_t                     cmd_q;
  logic                     last;      // index of last granted requester
  logic                     sel;       // index of current winner
  logic                     win;       // arbitration result this cycle
  logic                     any_req, complete, expire, retire;
  logic   [CNT_W-1:0]       cnt;
  logic                     transfer_q, err_q;
  logic   [DATA_W-1:0]      rdata_q;

  assign req       = {bus.req1, bus.req0};
  assign cmd_in[0] = {bus.rw0, bus.addr0, bus.wdata0};
  assign cmd_in[1] = {bus.rw1, bus.addr1, bus.wdata1};

  // next state plus one-cycle grant/finish/retire strobes
  always_comb begin
    state_nxt = state;
    grant     = '0;
    finish    = '0;
    retire    = 1'b0;
    any_req   = |req;
    // requester 1 wins alone, or on a tie when requester 0 went last
    win       = req[1] & (~req[0] | ~last);
    complete  = bus.penable & bus.pready;
    expire    = (cnt == CNT_W'(TIMEOUT - 1));
    case (state)
      IDLE: if (any_req) begin
        state_nxt  = XFER;
        grant[win] = 1'b1;
      end
      XFER: if (complete || expire) begin
        state_nxt   = DONE;
        finish[sel] = 1'b1;
      end
      DONE: begin
        state_nxt = IDLE;
        retire    = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // state register
  always_ff @(posedge pclk or negedge preset) begin
    if (!preset) state <= IDLE;
    else         state <= state_nxt;
  end

  // command latch, watchdog, read capture and round-robin pointer
  always_ff @(posedge pclk or negedge preset) begin
    if (!preset) begin
      cmd_q      <= '0;
      transfer_q <= 1'b0;
      err_q      <= 1'b0;
      rdata_q    <= '0;
      cnt        <= '0;
      sel        <= 1'b0;
      last       <= 1'b1;
    end else begin
      case (state)
        IDLE: if (any_req) begin
          cmd_q      <= cmd_in[win];
          sel        <= win;
          transfer_q <= 1'b1;
          cnt        <= '0;
        end
        XFER: begin
          cnt <= cnt + 1'b1;
          // completion takes priority over a coincident timeout
          if (complete) begin
            transfer_q <= 1'b0;
            if (cmd_q.rw) rdata_q <= bus.prdata;
          end else if (expire) begin
            transfer_q <= 1'b0;
            err_q      <= 1'b1;
          end
        end
        DONE: begin
          last  <= sel;
          err_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
    apb_req_arbiter_lane u_lane (
      .pclk   (pclk),
      .preset (preset),
      .grant  (grant[i]),
      .finish (finish[i]),
      .retire (retire),
      .gnt    (gnt[i]),
      .done   (done[i])
    );
  end

  assign bus.gnt0            = gnt[0];
  assign bus.gnt1            = gnt[1];
  assign bus.done0           = done[0];
  assign bus.done1           = done[1];
  assign bus.err             = err_q;
  assign bus.rdata           = rdata_q;
  assign bus.transfer        = transfer_q;
  assign bus.read_write      = cmd_q.rw;
  assign bus.apb_write_paddr = cmd_q.addr;
  assign bus.apb_read_paddr  = cmd_q.addr;
  assign bus.apb_write_data  = cmd_q.wdata;
endmodule
